// File: rtl/stream_demux_1to4_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] CH_A = 2'd0;
    localparam logic [SEL_W-1:0] CH_B = 2'd1;
    localparam logic [SEL_W-1:0] CH_C = 2'd2;
    localparam logic [SEL_W-1:0] CH_D = 2'd3;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

endpackage

// File: rtl/stream_demux_1to4_slot.sv
// One-entry holding register for a single output channel.
// A load in the same cycle as a drain keeps the slot full with the new beat.
module demux_slot #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Next-state: load wins over drain; data left as-is when draining.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Slot registers; reset discards any held beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/stream_demux_1to4.sv
// Registered 1-to-4 stream demultiplexer with explicit-select or
// round-robin destination and one holding slot per channel.
module stream_demux_1to4
    import demux_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             rr_mode,
    output logic [NCH-1:0]   out_valid,
    input  logic [NCH-1:0]   out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic [WIDTH-1:0] out_d,
    output logic [SEL_W-1:0] rr_ptr
);

    logic [SEL_W-1:0] dest;
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [NCH-1:0]   free;
    logic [NCH-1:0]   load;
    logic             accept;
    logic [WIDTH-1:0] slot_data [NCH];

    // Readiness depends only on the addressed channel, never on in_valid.
    assign dest     = (rr_mode == MODE_RR) ? rr_ptr_q : in_sel;
    assign free     = ~out_valid | out_ready;
    assign in_ready = free[dest] && !rst;
    assign accept   = in_valid && in_ready;

    // One-hot load strobe to the addressed slot.
    always_comb begin
        load = '0;
        if (accept) begin
            load[dest] = 1'b1;
        end
    end

    // Round-robin pointer advances only on accepted beats in RR mode.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && (rr_mode == MODE_RR)) begin
            rr_ptr_d = rr_ptr_q + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_slot
        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .load_data (in_data),
            .ready     (out_ready[i]),
            .valid     (out_valid[i]),
            .data      (slot_data[i])
        );
    end

    assign out_a  = slot_data[CH_A];
    assign out_b  = slot_data[CH_B];
    assign out_c  = slot_data[CH_C];
    assign out_d  = slot_data[CH_D];
    assign rr_ptr = rr_ptr_q;

endmodule
